dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that lets a CPU and a debug/loader
// requester share one byte-wide data memory. Each 32-bit word access is
// serialised into four big-endian byte beats (address wraps modulo 2^MEM_AW),
// followed by a one-cycle Ack to the granted requester.
//
// Ports:
//   CLK, Reset (async, active-low)
//   Cpu{Req,RW,Addr,WData} in / Cpu{RData,Ack} out : CPU word port
//   Dbg{Req,RW,Addr,WData} in / Dbg{RData,Ack} out : debug/loader word port
//   MemAddr, MemWE, MemWByte out / MemRByte in      : byte memory port
//   Busy : high whenever the FSM is not IDLE
//   Err  : misaligned-request flag, valid with Ack
//
// Build option: DMEMARB_ALIGN_CHK_EN -- when defined, requests with
// address[1:0] != 0 skip the memory beats and complete with Err = 1.
// When undefined, misaligned words are serviced normally and Err is 0.
module dmem_arbiter #(
    parameter int unsigned MEM_AW = 6
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              CpuReq,
    input  logic              CpuRW,
    input  logic [31:0]       CpuAddr,
    input  logic [31:0]       CpuWData,
    output logic [31:0]       CpuRData,
    output logic              CpuAck,
    input  logic              DbgReq,
    input  logic              DbgRW,
    input  logic [31:0]       DbgAddr,
    input  logic [31:0]       DbgWData,
    output logic [31:0]       DbgRData,
    output logic              DbgAck,
    output logic [MEM_AW-1:0] MemAddr,
    output logic              MemWE,
    output logic [7:0]        MemWByte,
    input  logic [7:0]        MemRByte,
    output logic              Busy,
    output logic              Err
);

    typedef enum logic [1:0] {IDLE, BEAT, ACK} state_t;

    state_t              state, state_d;
    logic [1:0]          beat, beat_d;
    logic                gnt_dbg, gnt_dbg_d;    // current grant: 1 = Dbg
    logic                last_dbg, last_dbg_d;  // last grant was Dbg
    logic [MEM_AW-1:0]   base, base_d;
    logic                rw, rw_d;
    logic [31:0]         wdata, wdata_d;

    logic [31:0]         cpu_rdata_d, dbg_rdata_d;
    logic                cpu_ack_d, dbg_ack_d;
    logic [MEM_AW-1:0]   mem_addr_d;
    logic                mem_we_d;
    logic [7:0]          mem_wbyte_d;
    logic                busy_d;

    // Request selection in IDLE
    logic                pick_dbg;
    logic [31:0]         req_addr;
    logic [1:0]          beat_n;

    // Address bits above the memory width are ignored by design
    logic                unused_addr_hi;
    assign unused_addr_hi = ^{CpuAddr[31:MEM_AW], DbgAddr[31:MEM_AW]};

    // Big-endian byte lane for beat k
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

`ifdef DMEMARB_ALIGN_CHK_EN
    logic err_d;
`else
    assign Err = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            beat     <= 2'd0;
            gnt_dbg  <= 1'b0;
            last_dbg <= 1'b1;   // CPU wins the first tie
            base     <= '0;
            rw       <= 1'b0;
            wdata    <= 32'd0;
            CpuRData <= 32'd0;
            DbgRData <= 32'd0;
            CpuAck   <= 1'b0;
            DbgAck   <= 1'b0;
            MemAddr  <= '0;
            MemWE    <= 1'b0;
            MemWByte <= 8'd0;
            Busy     <= 1'b0;
`ifdef DMEMARB_ALIGN_CHK_EN
            Err      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            beat     <= beat_d;
            gnt_dbg  <= gnt_dbg_d;
            last_dbg <= last_dbg_d;
            base     <= base_d;
            rw       <= rw_d;
            wdata    <= wdata_d;
            CpuRData <= cpu_rdata_d;
            DbgRData <= dbg_rdata_d;
            CpuAck   <= cpu_ack_d;
            DbgAck   <= dbg_ack_d;
            MemAddr  <= mem_addr_d;
            MemWE    <= mem_we_d;
            MemWByte <= mem_wbyte_d;
            Busy     <= busy_d;
`ifdef DMEMARB_ALIGN_CHK_EN
            Err      <= err_d;
`endif
        end
    end

    // Next-state and next-output logic; outputs are computed for the cycle
    // being entered so that every output comes straight from a flop.
    always_comb begin
        state_d     = state;
        beat_d      = beat;
        gnt_dbg_d   = gnt_dbg;
        last_dbg_d  = last_dbg;
        base_d      = base;
        rw_d        = rw;
        wdata_d     = wdata;
        cpu_rdata_d = CpuRData;
        dbg_rdata_d = DbgRData;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_wbyte_d = 8'd0;
        busy_d      = 1'b0;
`ifdef DMEMARB_ALIGN_CHK_EN
        err_d       = 1'b0;
`endif
        pick_dbg    = DbgReq && (!CpuReq || !last_dbg);
        req_addr    = pick_dbg ? DbgAddr : CpuAddr;
        beat_n      = beat + 2'd1;

        case (state)
            IDLE: begin
                if (CpuReq || DbgReq) begin
                    gnt_dbg_d  = pick_dbg;
                    last_dbg_d = pick_dbg;
                    base_d     = req_addr[MEM_AW-1:0];
                    rw_d       = pick_dbg ? DbgRW : CpuRW;
                    wdata_d    = pick_dbg ? DbgWData : CpuWData;
                    beat_d     = 2'd0;
                    busy_d     = 1'b1;
`ifdef DMEMARB_ALIGN_CHK_EN
                    if (req_addr[1:0] != 2'd0) begin
                        state_d   = ACK;
                        cpu_ack_d = !pick_dbg;
                        dbg_ack_d = pick_dbg;
                        err_d     = 1'b1;
                    end else
`endif
                    begin
                        state_d     = BEAT;
                        mem_addr_d  = req_addr[MEM_AW-1:0];
                        mem_we_d    = rw_d;
                        mem_wbyte_d = rw_d ? get_byte(wdata_d, 2'd0) : 8'd0;
                    end
                end
            end
            BEAT: begin
                busy_d = 1'b1;
                // Read byte for this beat is valid at MemAddr now
                if (!rw) begin
                    if (gnt_dbg) dbg_rdata_d = put_byte(DbgRData, beat, MemRByte);
                    else         cpu_rdata_d = put_byte(CpuRData, beat, MemRByte);
                end
                if (beat == 2'd3) begin
                    state_d   = ACK;
                    cpu_ack_d = !gnt_dbg;
                    dbg_ack_d = gnt_dbg;
                end else begin
                    beat_d      = beat_n;
                    mem_addr_d  = base + MEM_AW'(beat_n);
                    mem_we_d    = rw;
                    mem_wbyte_d = rw ? get_byte(wdata, beat_n) : 8'd0;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
